// File: rtl/top.sv
// TMR 4-bit universal shift register: three lockstep replicas with a bitwise majority voter.
// Define TMR_SCRUB_EN to have every replica compute its next state from the voted value.

module tmr_replica (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic       serial_in,
    input  logic [3:0] parallel_in,
    input  logic [3:0] src,
    output logic [3:0] value
);

    logic [3:0] reg_data;
    logic [3:0] reg_data_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_data <= 4'b0000;
        end else begin
            reg_data <= reg_data_next;
        end
    end

    // src is either this replica's own state or the voted value, chosen by the parent
    always_comb begin
        reg_data_next = src;
        if (enable) begin
            case (mode)
                2'b00, 2'b01: reg_data_next = {src[2:0], serial_in};
                2'b10:        reg_data_next = load ? parallel_in : {src[2:0], 1'b0};
                2'b11:        reg_data_next = load ? parallel_in : src;
            endcase
        end
    end

    assign value = reg_data;

endmodule

module top (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic       serial_in,
    input  logic [3:0] parallel_in,
    output logic       serial_out,
    output logic [3:0] parallel_out
);

    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] r3;
    logic [3:0] voted;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] s3;

    assign voted = (r1 & r2) | (r1 & r3) | (r2 & r3);

`ifdef TMR_SCRUB_EN
    assign s1 = voted;
    assign s2 = voted;
    assign s3 = voted;
`else
    assign s1 = r1;
    assign s2 = r2;
    assign s3 = r3;
`endif

    tmr_replica register_1 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .src         (s1),
        .value       (r1)
    );

    tmr_replica register_2 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .src         (s2),
        .value       (r2)
    );

    tmr_replica register_3 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .src         (s3),
        .value       (r3)
    );

    assign parallel_out = voted;
    assign serial_out   = voted[3];

endmodule

// File: tb/tb_top.sv
// Bench for the TMR shift register: directed vector table, fault-injection sequences,
// and randomized traffic against a replica-level reference model.

module tb_top;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic       serial_in;
    logic [3:0] parallel_in;
    logic       serial_out;
    logic [3:0] parallel_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TMR_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    top dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .load         (load),
        .serial_in    (serial_in),
        .parallel_in  (parallel_in),
        .serial_out   (serial_out),
        .parallel_out (parallel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the three replica values as plain numbers
    int m_rep [3];

    function automatic int m_vote();
        int v = 0;
        for (int b = 0; b < 4; b++) begin
            int c = 0;
            for (int k = 0; k < 3; k++) c += (m_rep[k] >> b) & 1;
            if (c >= 2) v += (1 << b);
        end
        return v;
    endfunction

    function automatic void m_edge();
        int nxt [3];
        for (int k = 0; k < 3; k++) begin
            int s = SCRUB ? m_vote() : m_rep[k];
            if (!enable)             nxt[k] = s;
            else if (mode < 2)       nxt[k] = (s * 2 + int'(serial_in)) % 16;
            else if (load)           nxt[k] = int'(parallel_in);
            else if (mode == 2'b10)  nxt[k] = (s * 2) % 16;
            else                     nxt[k] = s;
        end
        for (int k = 0; k < 3; k++) m_rep[k] = nxt[k];
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic l,
                         input logic si, input logic [3:0] pi);
        enable = e; mode = m; load = l; serial_in = si; parallel_in = pi;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic check_model(input string name);
        logic [3:0] v;
        v = 4'(m_vote());
        check({name, ".par"}, parallel_out, v);
        check({name, ".ser"}, {3'b000, serial_out}, {3'b000, v[3]});
    endtask

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic       ld;
        logic       si;
        logic [3:0] pi;
        logic [3:0] po;
        logic       so;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 1'b1, 4'h0, 4'b0011, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'h0, 4'b1101, 1'b1};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'h0, 4'b1011, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'h0, 4'b0111, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'h0, 4'b1111, 1'b1};
        vecs[8]  = '{1'b0, 2'b11, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b1};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 1'b0, 4'h0, 4'b1111, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h6, 4'b0110, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 4'b1100, 1'b1};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b1};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 4'b0000, 1'b0};
        vecs[14] = '{1'b1, 2'b11, 1'b1, 1'b0, 4'hE, 4'b1110, 1'b1};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 4'b1110, 1'b1};

        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) m_rep[k] = 0;
        #12;
        check("reset.par", parallel_out, 4'b0000);
        check("reset.ser", {3'b000, serial_out}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Directed table, starting from the cleared state
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].ld, vecs[i].si, vecs[i].pi);
            tick();
            check($sformatf("vec%0d.par", i), parallel_out, vecs[i].po);
            check($sformatf("vec%0d.ser", i), {3'b000, serial_out}, {3'b000, vecs[i].so});
        end

        // Single replica: corrupt register_3's next state across one edge in PIPO hold
        drive(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
        force dut.register_3.reg_data_next = 4'b1111;
        tick();
        m_rep[2] = 15;
        release dut.register_3.reg_data_next;
        serial_in = 1'b1;
        #1;
        check("seu.par", parallel_out, 4'b1110);
        check("seu.r3", dut.register_3.reg_data, 4'b1111);
        tick();
        check("seu_next.par", parallel_out, 4'b1110);
        check("seu_next.r3", dut.register_3.reg_data, SCRUB ? 4'b1110 : 4'b1111);
        check("seu_next.model_r3", dut.register_3.reg_data, 4'(m_rep[2]));

        // Two replicas: overwrite register_2 and register_3 state mid-cycle
        force dut.register_2.reg_data = 4'b0111;
        force dut.register_3.reg_data = 4'b0111;
        m_rep[1] = 7;
        m_rep[2] = 7;
        #1;
        check("dmr.par", parallel_out, 4'b0111);
        check("dmr.ser", {3'b000, serial_out}, 4'b0000);
        #1;
        release dut.register_2.reg_data;
        release dut.register_3.reg_data;
        serial_in = 1'b0;
        tick();
        check("dmr_after.par", parallel_out, 4'b0111);
        check("dmr_after.r1", dut.register_1.reg_data, SCRUB ? 4'b0111 : 4'b1110);

        // Re-align all replicas with a parallel load
        drive(1'b1, 2'b11, 1'b1, 1'b0, 4'h9);
        tick();
        check_model("reload");
        check("reload.r3", dut.register_3.reg_data, 4'b1001);

        // Randomized traffic with occasional asynchronous reset mid-cycle
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) m_rep[k] = 0;
                check("rand_rst.par", parallel_out, 4'b0000);
                check("rand_rst.ser", {3'b000, serial_out}, 4'b0000);
                #1;
                rst = 1'b1;
            end
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
